// File: rtl/lasernet_link_pkg.sv
// Line-format constants and state type shared by both ends of the laser link.
// The receiver imports the same package so the two ends cannot drift apart.
package lasernet_link_pkg;

    localparam logic LINK_IDLE_LEVEL  = 1'b0;
    localparam logic LINK_START_LEVEL = 1'b1;
    localparam logic LINK_STOP_LEVEL  = 1'b0;

    localparam int DEFAULT_CLK_PER_BIT = 50;
    localparam int DEFAULT_PKT_LENGTH  = 32;
    localparam int DEFAULT_STOP_BITS   = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } txState_e;

endpackage

// File: rtl/serial_tx.sv
// Laser-link serial transmitter.
// Each frame is one high start bit, the data bits LSB first, then low stop bits.
module serial_tx
    import lasernet_link_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int PKT_LENGTH  = DEFAULT_PKT_LENGTH,
    parameter int STOP_BITS   = DEFAULT_STOP_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PKT_LENGTH-1:0] data,
    input  logic                  send,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int BW = $clog2(PKT_LENGTH + 1);
    localparam int SW = $clog2(STOP_BITS + 1);

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(PKT_LENGTH - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    txState_e              state_q;
    logic [CW-1:0]         clkCnt_q;
    logic [BW-1:0]         bitCnt_q;
    logic [SW-1:0]         stopCnt_q;
    logic [PKT_LENGTH-1:0] shift_q;
    logic [PKT_LENGTH-1:0] shift_d;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    assign shift_d = shift_q >> 1;

    // Outputs are computed one cycle ahead so tx always comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            clkCnt_q  <= '0;
            bitCnt_q  <= '0;
            stopCnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= LINK_IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    tx_q   <= LINK_IDLE_LEVEL;
                    busy_q <= 1'b0;
                    if (send) begin
                        shift_q   <= data;
                        clkCnt_q  <= '0;
                        bitCnt_q  <= '0;
                        stopCnt_q <= '0;
                        state_q   <= TX_START;
                        tx_q      <= LINK_START_LEVEL;
                        busy_q    <= 1'b1;
                    end
                end
                TX_START: begin
                    if (clkCnt_q == CLK_LAST) begin
                        clkCnt_q <= '0;
                        state_q  <= TX_DATA;
                        tx_q     <= shift_q[0];
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (clkCnt_q == CLK_LAST) begin
                        clkCnt_q <= '0;
                        shift_q  <= shift_d;
                        if (bitCnt_q == BIT_LAST) begin
                            bitCnt_q  <= '0;
                            stopCnt_q <= '0;
                            state_q   <= TX_STOP;
                            tx_q      <= LINK_STOP_LEVEL;
                        end else begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                            tx_q     <= shift_d[0];
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    tx_q <= LINK_STOP_LEVEL;
                    if (clkCnt_q == CLK_LAST) begin
                        clkCnt_q <= '0;
                        if (stopCnt_q == STOP_LAST) begin
                            stopCnt_q <= '0;
                            state_q   <= TX_IDLE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            stopCnt_q <= stopCnt_q + 1'b1;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= LINK_IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: frame timing, ignored send, back-to-back, reset, edge parameters.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       send;
    logic       tx, busy, done;

    logic       dataE;
    logic       sendE;
    logic       txE, busyE, doneE;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    serial_tx #(.CLK_PER_BIT(4), .PKT_LENGTH(8), .STOP_BITS(2)) dut (
        .clk(clk), .rst(rst), .data(data), .send(send),
        .tx(tx), .busy(busy), .done(done)
    );

    serial_tx #(.CLK_PER_BIT(2), .PKT_LENGTH(1), .STOP_BITS(1)) dutEdge (
        .clk(clk), .rst(rst), .data(dataE), .send(sendE),
        .tx(txE), .busy(busyE), .done(doneE)
    );

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offset k counts cycles after the accept edge; k=1 is the first start-bit cycle.
    function automatic logic expTx(input logic [7:0] d, input int k);
        if (k >= 1 && k <= 4)       return 1'b1;
        else if (k >= 5 && k <= 36) return d[(k - 5) / 4];
        else                        return 1'b0;
    endfunction

    task automatic applyStimulus(input logic [7:0] d);
        data = d;
        send = 1'b1;
        tick();
        send = 1'b0;
        data = 8'h00;
    endtask

    task automatic runFrame(input logic [7:0] d, input int injectAt, input int lastK,
                            input bit chain, input logic [7:0] chainData);
        for (int k = 1; k <= lastK; k++) begin
            checkOutput($sformatf("tx d=%h k=%0d", d, k), tx, expTx(d, k));
            checkOutput($sformatf("busy d=%h k=%0d", d, k), busy, (k >= 1 && k <= 44));
            checkOutput($sformatf("done d=%h k=%0d", d, k), done, (k == 45));
            send = 1'b0;
            if (k == injectAt) begin
                send = 1'b1;
                data = 8'hFF;
            end
            if (chain && k == lastK) begin
                send = 1'b1;
                data = chainData;
            end
            tick();
        end
        send = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        send  = 1'b0;
        data  = 8'h00;
        sendE = 1'b0;
        dataE = 1'b0;
        tick();
        tick();
        checkOutput("reset tx", tx, 1'b0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset edge tx", txE, 1'b0);
        rst = 1'b0;
        repeat (3) tick();

        $display("[TB] single frame A5");
        applyStimulus(8'hA5);
        runFrame(8'hA5, 0, 47, 1'b0, 8'h00);

        $display("[TB] send ignored while busy");
        applyStimulus(8'h5A);
        runFrame(8'h5A, 10, 52, 1'b0, 8'h00);

        $display("[TB] back-to-back frames");
        applyStimulus(8'hC3);
        runFrame(8'hC3, 0, 45, 1'b1, 8'h3C);
        runFrame(8'h3C, 0, 47, 1'b0, 8'h00);

        $display("[TB] reset mid-data");
        applyStimulus(8'hA5);
        runFrame(8'hA5, 0, 12, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("post-reset tx", tx, 1'b0);
        checkOutput("post-reset busy", busy, 1'b0);
        checkOutput("post-reset done", done, 1'b0);
        repeat (2) tick();
        applyStimulus(8'h01);
        runFrame(8'h01, 0, 47, 1'b0, 8'h00);

        $display("[TB] edge parameters");
        dataE = 1'b1;
        sendE = 1'b1;
        tick();
        sendE = 1'b0;
        dataE = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("edge tx k=%0d", k), txE, (k <= 4));
            checkOutput($sformatf("edge busy k=%0d", k), busyE, (k <= 6));
            checkOutput($sformatf("edge done k=%0d", k), doneE, (k == 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
